stage1_ti: RTL

STAGE1_TI -- requirements
Module: stage1_ti

---
 rtl/stage1_ti.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stage1_ti.sv
// stage1_ti: first stage of a first-order masked AES S-box. Each share is mapped into the
// tower field GF((2^4)^2), and the shared norm d = h*l ^ N*(h^l)^2 is formed with a DOM-indep multiplier.
module stage1_ti (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [3:0] r,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] h0,
  output logic [3:0] h1,
  output logic [3:0] l0,
  output logic [3:0] l1,
  output logic       out_valid,
  output logic       sbox_valid,
  output logic       busy
);

  // GF(2^4) uses the polynomial x^4+x+1; N = x^3 makes Y^2+Y+N irreducible over it.
  localparam logic [3:0] N_SCALE = 4'h8;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] z);
    return {z[3], z[3] ^ z[1], z[2], z[2] ^ z[0]};
  endfunction

  function automatic logic [3:0] sq_scale(input logic [3:0] z);
    return gf16_mul(N_SCALE, gf16_sq(z));
  endfunction

  // AES basis -> tower basis {h,l}, element = h*Y^16 ^ l*Y with Y = 0xAE in the AES field.
  function automatic logic [7:0] map_m(input logic [7:0] t);
    logic [3:0] hh;
    logic [3:0] ll;
    hh[0] = t[0] ^ t[4] ^ t[5] ^ t[6] ^ t[7];
    hh[1] = t[1] ^ t[5];
    hh[2] = t[1] ^ t[2] ^ t[3] ^ t[6] ^ t[7];
    hh[3] = t[2] ^ t[5] ^ t[6];
    ll[0] = t[0] ^ t[2] ^ t[3] ^ t[5];
    ll[1] = t[1] ^ t[2] ^ t[3] ^ t[7];
    ll[2] = t[2] ^ t[3] ^ t[4] ^ t[5] ^ t[7];
    ll[3] = t[2] ^ t[6] ^ t[7];
    return {hh, ll};
  endfunction

  logic [7:0] w_m0;
  logic [7:0] w_m1;
  logic [3:0] w_h0, w_l0, w_h1, w_l1;
  logic [3:0] w_a0, w_a1, w_c01, w_c10;

  assign w_m0  = map_m(x0);
  assign w_m1  = map_m(x1);
  assign w_h0  = w_m0[7:4];
  assign w_l0  = w_m0[3:0];
  assign w_h1  = w_m1[7:4];
  assign w_l1  = w_m1[3:0];
  // Inner terms stay within one share; cross terms are refreshed by r before any recombination.
  assign w_a0  = gf16_mul(w_h0, w_l0) ^ sq_scale(w_h0 ^ w_l0);
  assign w_a1  = gf16_mul(w_h1, w_l1) ^ sq_scale(w_h1 ^ w_l1);
  assign w_c01 = gf16_mul(w_h0, w_l1) ^ r;
  assign w_c10 = gf16_mul(w_h1, w_l0) ^ r;

  logic [3:0] r_a0_p0, r_a1_p0, r_c01_p0, r_c10_p0;
  logic [3:0] r_h0_p0, r_h1_p0, r_l0_p0, r_l1_p0;
  logic       r_vld_p0, r_vld_p1, r_vld_p2;

  // ---- stage p0: share-domain registers, loaded every cycle ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a0_p0  <= 4'h0;
      r_a1_p0  <= 4'h0;
      r_c01_p0 <= 4'h0;
      r_c10_p0 <= 4'h0;
      r_h0_p0  <= 4'h0;
      r_h1_p0  <= 4'h0;
      r_l0_p0  <= 4'h0;
      r_l1_p0  <= 4'h0;
    end else begin
      r_a0_p0  <= w_a0;
      r_a1_p0  <= w_a1;
      r_c01_p0 <= w_c01;
      r_c10_p0 <= w_c10;
      r_h0_p0  <= w_h0;
      r_h1_p0  <= w_h1;
      r_l0_p0  <= w_l0;
      r_l1_p0  <= w_l1;
    end
  end

  // ---- valid shift: p0 is this stage, p1/p2 track the two downstream stages ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= in_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign out0       = r_a0_p0 ^ r_c01_p0;
  assign out1       = r_a1_p0 ^ r_c10_p0;
  assign h0         = r_h0_p0;
  assign h1         = r_h1_p0;
  assign l0         = r_l0_p0;
  assign l1         = r_l1_p0;
  assign out_valid  = r_vld_p0;
  assign sbox_valid = r_vld_p2;
  assign busy       = r_vld_p0 | r_vld_p1 | r_vld_p2 | in_valid;

endmodule
